// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and byte-lane helpers for the data memory controller
// Contents: access size encodings, controller state enum, byte rotate and
// load-extension helpers. Helpers work on the widest supported row (16 lanes);
// callers pass the active lane count and truncate the result.
package dmem_pkg;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;

  localparam int MAX_LANES = 16;
  localparam int MAX_W     = 8 * MAX_LANES;

  typedef enum logic [1:0] {IDLE, RD, RESP} state_e;

  // Byte i of d moves to byte (i + sh) mod lanes.
  function automatic logic [MAX_W-1:0] rot_left_bytes(input logic [MAX_W-1:0] d,
                                                      input logic [3:0] sh,
                                                      input int lanes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) r[8*((i + int'(sh)) & (lanes - 1)) +: 8] = d[8*i +: 8];
    end
    return r;
  endfunction

  // Byte (i + sh) mod lanes of d moves to byte i.
  function automatic logic [MAX_W-1:0] rot_right_bytes(input logic [MAX_W-1:0] d,
                                                       input logic [3:0] sh,
                                                       input int lanes);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) r[8*i +: 8] = d[8*((i + int'(sh)) & (lanes - 1)) +: 8];
    end
    return r;
  endfunction

  // Bytes above the access width become copies of the access sign bit, or zero.
  function automatic logic [MAX_W-1:0] extend(input logic [MAX_W-1:0] d,
                                              input logic [2:0] size,
                                              input logic sgn);
    logic [MAX_W-1:0] r;
    int nb;
    logic s;
    nb = 1 << size;
    if (nb > MAX_LANES) nb = MAX_LANES;
    s = sgn & d[8*nb-1];
    r = d;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i >= nb) r[8*i +: 8] = {8{s}};
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// rtl/dmem_ctrl_if.sv - request/response handshake bundle between load/store stage and dmem_ctrl
// Signals: req_valid/req_ready/req_we/req_addr[63:0]/req_wdata/req_size[2:0]/req_signed,
// resp_valid/resp_ready/resp_rdata/resp_err. master = load/store stage, slave = dmem_ctrl.
interface dmem_ctrl_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [63:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [2:0]        req_size;
  logic              req_signed;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_signed, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_signed, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane.sv
// rtl/dmem_lane.sv - one byte lane of the data SRAM, 8 bits x DEPTH, 1-cycle read
// Ports: clk; en (read strobe); we (write enable); addr (row); wdata[7:0]; rdata[7:0]
// (valid the cycle after en). Contents are never reset.
module dmem_lane #(
  parameter  int DEPTH = 131072,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (en) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - byte-laned data memory controller with misaligned/row-crossing access
// Ports: clk; rst_n (async, active low); bus (dmem_ctrl_if.slave): one request accepted
// at a time, store/error response one edge after accept, load response two edges after.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int LANES            = 8,
  parameter int DEPTH            = 131072,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_ctrl_if.slave bus
);
  localparam int         DATA_W   = 8 * LANES;
  localparam int         COL_W    = $clog2(LANES);
  localparam int         ROW_W    = $clog2(DEPTH);
  localparam logic [2:0] MAX_SIZE = 3'(COL_W);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [2:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row, row_p1;
  logic [31:0]       nbytes;
  logic              accept, req_err;
  logic              err_size, err_mis, err_range, err_cross;
  logic [LANES-1:0]  lane_we;
  logic [DATA_W-1:0] wdata_rot, rd_word, ld_word;

  assign col    = bus.req_addr[COL_W-1:0];
  assign row    = bus.req_addr[COL_W +: ROW_W];
  assign row_p1 = row + ROW_W'(1);
  assign nbytes = 32'd1 << bus.req_size;

  assign err_size  = bus.req_size > MAX_SIZE;
  assign err_mis   = !ALLOW_MISALIGNED && ((bus.req_addr & (64'(nbytes) - 64'd1)) != 64'd0);
  assign err_range = (bus.req_addr >> (COL_W + ROW_W)) != 64'd0;
  // Crossing out of the last row is rejected rather than wrapped to row 0.
  assign err_cross = (32'(col) + nbytes > 32'(LANES)) && (row == ROW_W'(DEPTH - 1));
  assign req_err   = err_size || err_mis || err_range || err_cross;

  assign bus.req_ready = rst_n && (state_q == IDLE);
  assign accept        = bus.req_valid && bus.req_ready;

  assign wdata_rot = DATA_W'(rot_left_bytes(MAX_W'(bus.req_wdata), 4'(col), LANES));
  assign ld_word   = DATA_W'(extend(rot_right_bytes(MAX_W'(rd_word), 4'(col_q), LANES),
                                    size_q, sgn_q));

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    // off = position of lane i's byte within the access; lanes below col wrap to next row
    logic [COL_W-1:0] off;
    logic [ROW_W-1:0] lane_addr;
    assign off        = COL_W'(i) - col;
    assign lane_addr  = (COL_W'(i) < col) ? row_p1 : row;
    assign lane_we[i] = accept && bus.req_we && !req_err && (32'(off) < nbytes);

    dmem_lane #(.DEPTH(DEPTH)) u_lane (
      .clk   (clk),
      .en    (accept && !bus.req_we),
      .we    (lane_we[i]),
      .addr  (lane_addr),
      .wdata (wdata_rot[8*i +: 8]),
      .rdata (rd_word[8*i +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          col_d   = col;
          size_d  = bus.req_size;
          sgn_d   = bus.req_signed;
          err_d   = req_err;
          rdata_d = '0;
          state_d = (req_err || bus.req_we) ? RESP : RD;
        end
      end
      RD: begin
        rdata_d = ld_word;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      size_q  <= '0;
      sgn_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - self-checking bench for dmem_ctrl (two instances: misaligned allowed / not)
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid_a, req_valid_b, req_we, req_signed, resp_ready, sel;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;

  dmem_ctrl_if a_if ();
  dmem_ctrl_if b_if ();

  assign a_if.req_valid  = req_valid_a;
  assign a_if.req_we     = req_we;
  assign a_if.req_addr   = req_addr;
  assign a_if.req_wdata  = req_wdata;
  assign a_if.req_size   = req_size;
  assign a_if.req_signed = req_signed;
  assign a_if.resp_ready = resp_ready;
  assign b_if.req_valid  = req_valid_b;
  assign b_if.req_we     = req_we;
  assign b_if.req_addr   = req_addr;
  assign b_if.req_wdata  = req_wdata;
  assign b_if.req_size   = req_size;
  assign b_if.req_signed = req_signed;
  assign b_if.resp_ready = resp_ready;

  dmem_ctrl #(.LANES(8), .DEPTH(16), .ALLOW_MISALIGNED(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(a_if));
  dmem_ctrl #(.LANES(8), .DEPTH(16), .ALLOW_MISALIGNED(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(b_if));

  logic        cur_ready, cur_rvalid, cur_err;
  logic [63:0] cur_rdata;
  assign cur_ready  = sel ? b_if.req_ready  : a_if.req_ready;
  assign cur_rvalid = sel ? b_if.resp_valid : a_if.resp_valid;
  assign cur_err    = sel ? b_if.resp_err   : a_if.resp_err;
  assign cur_rdata  = sel ? b_if.resp_rdata : a_if.resp_rdata;

  int n_vec = 0;
  int n_bad = 0;

  // Reference memory for instance A: 16 rows x 8 bytes as a flat byte array.
  logic [7:0] mem_m [128];

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [2:0]  size;
    logic        sgn;
    logic        exp_err;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic we, logic [63:0] addr, logic [63:0] wd, logic [2:0] sz,
                              logic sg, logic e, logic [63:0] rd);
    vec_t t;
    t.we = we; t.addr = addr; t.wdata = wd; t.size = sz; t.sgn = sg;
    t.exp_err = e; t.exp_rdata = rd;
    return t;
  endfunction

  function automatic logic m_err(logic [63:0] a, logic [2:0] sz, bit allow_mis);
    int n;
    n = 1 << sz;
    if (sz > 3) return 1'b1;
    if (!allow_mis && (a % 64'(n)) != 0) return 1'b1;
    if (a >= 64'd128) return 1'b1;
    if ((a % 8) + 64'(n) > 8 && (a / 8) == 15) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_load(logic [63:0] a, logic [2:0] sz, logic sg);
    logic [63:0] r;
    int n;
    n = 1 << sz;
    r = 64'd0;
    for (int k = 0; k < n; k++) r = r | (64'(mem_m[int'(a) + k]) << (8 * k));
    if (sg && r[8*n-1] && n < 8) r = r | (~64'd0 << (8 * n));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wd,
                     input logic [2:0] sz, input logic sg,
                     output logic err, output logic [63:0] rd, output int lat);
    int w;
    @(negedge clk);
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_signed = sg;
    if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
    w = 0;
    while (!cur_ready && w < 50) begin @(negedge clk); w++; end
    @(posedge clk); #1;
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    lat = 1;
    while (!cur_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
    err = cur_err;
    rd  = cur_rdata;
    if (!cur_rvalid || w >= 50) lat = 99;
    @(posedge clk); #1;
  endtask

  task automatic run(input string name, input logic we, input logic [63:0] addr,
                     input logic [63:0] wd, input logic [2:0] sz, input logic sg,
                     input logic exp_err, input logic [63:0] exp_rd);
    logic err;
    logic [63:0] rd;
    int lat;
    txn(we, addr, wd, sz, sg, err, rd, lat);
    check({name, ".err"}, 64'(err), 64'(exp_err));
    check({name, ".rdata"}, rd, exp_rd);
    check({name, ".lat"}, 64'(lat), (we || exp_err) ? 64'd1 : 64'd2);
    if (!sel && we && !m_err(addr, sz, 1'b1))
      for (int k = 0; k < (1 << sz); k++) mem_m[int'(addr) + k] = wd[8*k +: 8];
  endtask

  initial begin
    logic [63:0] d, a;
    logic [2:0]  sz;
    logic        we, sg, e;

    rst_n = 1'b0; sel = 1'b0; resp_ready = 1'b1;
    req_valid_a = 1'b1; req_valid_b = 1'b0; req_we = 1'b0; req_signed = 1'b0;
    req_addr = 64'h40; req_wdata = 64'd0; req_size = SZ_D;

    // Reset held with a request pending: nothing accepted, no response.
    repeat (3) begin
      @(negedge clk);
      check("rst.resp_valid", 64'(a_if.resp_valid), 64'd0);
      check("rst.req_ready", 64'(a_if.req_ready), 64'd0);
    end
    req_valid_a = 1'b0;
    @(negedge clk); rst_n = 1'b1; #1;
    check("rst.ready_after", 64'(a_if.req_ready), 64'd1);
    check("rst.rdata", a_if.resp_rdata, 64'd0);
    @(posedge clk); #1;
    check("rst.no_resp", 64'(a_if.resp_valid), 64'd0);

    // Fill instance A so each byte holds its own address.
    for (int r = 0; r < 16; r++) begin
      for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(r * 8 + k);
      run($sformatf("init%0d", r), 1'b1, 64'(r * 8), d, SZ_D, 1'b0, 1'b0, 64'd0);
    end

    tbl.push_back(mk(1, 64'h40, 64'h1122334455667788, SZ_D, 0, 0, 64'd0));
    tbl.push_back(mk(0, 64'h40, 64'd0, SZ_D, 1, 0, 64'h1122334455667788));
    tbl.push_back(mk(1, 64'h46, 64'h00000000DEADBEEF, SZ_W, 0, 0, 64'd0));
    tbl.push_back(mk(0, 64'h46, 64'd0, SZ_W, 1, 0, 64'hFFFFFFFFDEADBEEF));
    tbl.push_back(mk(0, 64'h48, 64'd0, SZ_B, 0, 0, 64'h00000000000000AD));
    tbl.push_back(mk(0, 64'h47, 64'd0, SZ_H, 1, 0, 64'hFFFFFFFFFFFFADBE));
    tbl.push_back(mk(0, 64'h44, 64'd0, SZ_W, 0, 0, 64'h00000000BEEF3344));
    tbl.push_back(mk(0, 64'h40, 64'd0, SZ_B, 1, 0, 64'hFFFFFFFFFFFFFF88));
    tbl.push_back(mk(1, 64'h7C, 64'hAAAAAAAAAAAAAAAA, SZ_D, 0, 1, 64'd0));
    tbl.push_back(mk(0, 64'h78, 64'd0, SZ_D, 0, 0, 64'h7F7E7D7C7B7A7978));
    tbl.push_back(mk(0, 64'h00, 64'd0, SZ_D, 0, 0, 64'h0706050403020100));
    tbl.push_back(mk(0, 64'h00, 64'd0, 3'd4, 0, 1, 64'd0));
    tbl.push_back(mk(0, 64'h80, 64'd0, SZ_B, 0, 1, 64'd0));
    tbl.push_back(mk(0, 64'h8000000000000010, 64'd0, SZ_B, 0, 1, 64'd0));
    tbl.push_back(mk(0, 64'h7F, 64'd0, SZ_B, 1, 0, 64'h000000000000007F));
    foreach (tbl[i])
      run($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size,
          tbl[i].sgn, tbl[i].exp_err, tbl[i].exp_rdata);

    // Backpressure: response held for 5 cycles while a new store request is ignored.
    d = m_load(64'h40, SZ_D, 1'b1);
    @(negedge clk);
    resp_ready = 1'b0; req_we = 1'b0; req_addr = 64'h40; req_size = SZ_D; req_signed = 1'b1;
    req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0;
    @(posedge clk); #1;
    check("bp.lat", 64'(a_if.resp_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid_a = 1'b1; req_we = 1'b1; req_addr = 64'h0; req_wdata = 64'hFFFFFFFFFFFFFFFF;
      check("bp.valid", 64'(a_if.resp_valid), 64'd1);
      check("bp.rdata", a_if.resp_rdata, d);
      check("bp.err", 64'(a_if.resp_err), 64'd0);
      check("bp.ready", 64'(a_if.req_ready), 64'd0);
    end
    req_valid_a = 1'b0; req_we = 1'b0;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    check("bp.done_valid", 64'(a_if.resp_valid), 64'd0);
    check("bp.done_ready", 64'(a_if.req_ready), 64'd1);
    @(posedge clk); #1;
    check("bp.no_extra", 64'(a_if.resp_valid), 64'd0);
    run("bp.row0", 1'b0, 64'h0, 64'd0, SZ_D, 1'b0, 1'b0, m_load(64'h0, SZ_D, 1'b0));

    // Instance B rejects any access not aligned to its size.
    sel = 1'b1;
    run("mis.ld42", 1'b0, 64'h42, 64'd0, SZ_W, 1'b0, 1'b1, 64'd0);
    run("mis.st42", 1'b1, 64'h42, 64'h12345678, SZ_W, 1'b0, 1'b1, 64'd0);
    run("mis.st44", 1'b1, 64'h44, 64'h0BADF00D, SZ_W, 1'b0, 1'b0, 64'd0);
    run("mis.ld44", 1'b0, 64'h44, 64'd0, SZ_W, 1'b0, 1'b0, 64'h000000000BADF00D);
    run("mis.ld46", 1'b0, 64'h46, 64'd0, SZ_H, 1'b1, 1'b0, 64'h0000000000000BAD);
    run("mis.ld45", 1'b0, 64'h45, 64'd0, SZ_H, 1'b0, 1'b1, 64'd0);
    run("mis.st44d", 1'b1, 64'h44, 64'd0, SZ_D, 1'b0, 1'b1, 64'd0);
    sel = 1'b0;

    // Reset while the load is in flight drops it; memory survives.
    @(negedge clk);
    req_we = 1'b0; req_addr = 64'h40; req_size = SZ_D; req_signed = 1'b0; req_valid_a = 1'b1;
    @(posedge clk); #1;
    req_valid_a = 1'b0; rst_n = 1'b0; #1;
    check("rrd.valid", 64'(a_if.resp_valid), 64'd0);
    check("rrd.ready", 64'(a_if.req_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("rrd.no_stale", 64'(a_if.resp_valid), 64'd0);
    end
    run("rrd.fresh", 1'b0, 64'h40, 64'd0, SZ_D, 1'b0, 1'b0, m_load(64'h40, SZ_D, 1'b0));

    // Random traffic against the byte-array model.
    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      a  = 64'($urandom_range(0, 143));
      if ($urandom_range(0, 15) == 0) a = a | (64'd1 << $urandom_range(7, 63));
      d  = {$urandom, $urandom};
      e  = m_err(a, sz, 1'b1);
      run($sformatf("rnd%0d", i), we, a, d, sz, sg, e,
          (e || we) ? 64'd0 : m_load(a, sz, sg));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised successor to the current byte-lane data memory unit. It sits between the load/store stage and a private byte-laned SRAM, and uses a valid/ready request and response handshake with one transaction outstanding. It supports sub-word and misaligned accesses, including accesses that cross a row, with sign or zero extension. It also reports errors for misalignment, out-of-range addresses and illegal sizes instead of silently wrapping.

Parameters:
LANES, 8, bytes per row; power of two, 2..16. DATA_W = 8*LANES is a derived localparam.
DEPTH, 131072, rows per lane; power of two.
ALLOW_MISALIGNED, 1, 1 = unaligned accesses are serviced; 0 = unaligned accesses return an error.

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request can be accepted
req_we  in  1  1 = store, 0 = load
req_addr  in  64  byte address
req_wdata  in  DATA_W  store data, right-justified
req_size  in  3  log2 of access bytes: 0 = byte, up to log2(LANES)
req_signed  in  1  sign-extend load result
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  DATA_W  load data after extension; 0 for stores and errors
resp_err  out  1  request rejected

Behaviour:
- Reset values: req_ready=1 once rst_n is high; resp_valid=0; resp_rdata=0; resp_err=0; FSM=IDLE. SRAM contents are not cleared.
- Address decode: col = addr[log2(LANES)-1:0]; row = addr >> log2(LANES). Lane i uses row+1 when i<col, else row. Little-endian byte order.
- FSM states: IDLE, RD, RESP.
- req_ready = (state==IDLE). A request is accepted on any edge where req_valid && req_ready.
- Error check, evaluated at accept. An error is flagged if any of these hold:
  - req_size > log2(LANES);
  - ALLOW_MISALIGNED=0 and addr is not a multiple of 2^size;
  - any address bit at or above log2(LANES*DEPTH) is set;
  - the access crosses a row boundary (col + 2^size > LANES) and row == DEPTH-1. This is an error, not a wrap.
- On error: no lane is written. Go to RESP with resp_err=1 and rdata=0. resp_valid rises after the accepting edge (latency 1).
- Store, no error: byte-enable mask ((1<<2^size)-1) is rotated left by col. wdata is rotated left by 8*col. Lanes are written on the accepting edge. Go to RESP with rdata=0, err=0 (latency 1).
- Load, no error: lane addresses are presented on the accepting edge and the state goes to RD. Lane SRAM read latency is 1. On the next edge, the lane data is rotated right by 8*col, bits above 8*2^size are replaced with the sign bit (req_signed=1) or 0, and the result is registered. The state goes to RESP, so resp_valid rises 2 edges after accept.
- Size and signed attributes are captured at accept. Later changes on the request inputs have no effect.
- RESP: resp_valid=1 and outputs are held stable while resp_ready=0. On an edge with resp_ready=1 the state goes to IDLE. The next request can be accepted on the following edge, so there is no same-cycle turnaround.
- Read-after-write to overlapping bytes always returns the new data, because transactions are serialised.
- Reset mid-operation: the FSM goes to IDLE and resp_valid=0 immediately. A pending load is dropped. A store already written on its accepting edge remains in memory.

Decomposition:
- dmem_pkg contains:
  - size encodings SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3;
  - the state enum {IDLE, RD, RESP};
  - functions rot_left_bytes, rot_right_bytes and extend(data, size, signed).
- Sub-module dmem_lane: an 8-bit x DEPTH synchronous RAM with a single write enable and 1-cycle read. It is instantiated LANES times via generate.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with req_valid=1 -> resp_valid=0 and no accept. After release, req_ready=1.
2. Aligned store of size 3, data 0x1122334455667788 to addr 0x40, then signed load of size 3 from 0x40 -> store resp_err=0 with latency 1; load rdata=0x1122334455667788 with resp_valid exactly 2 edges after accept.
3. Row-crossing store of size 2, data 0xDEADBEEF to 0x46, followed by these loads:
   - signed size 2 at 0x46 -> 0xFFFFFFFFDEADBEEF;
   - unsigned size 0 at 0x48 -> 0x00000000000000AD;
   - signed size 1 at 0x47 -> 0xFFFFFFFFFFFFADBE.
4. Backpressure: load with resp_ready=0 for 5 cycles -> resp_valid, rdata and err stay stable; req_ready=0 and a new req_valid is ignored. Raise resp_ready -> handshake completes and req_ready=1 on the next cycle.
5. Errors:
   - ALLOW_MISALIGNED=0, size 2 at 0x42 -> err=1, rdata=0;
   - DEPTH=16, store of size 3 at row 15 with col 4 -> err=1, and row 15 / row 0 contents unchanged when read back;
   - req_size=4 with LANES=8 -> err=1.
6. Reset while in RD -> resp_valid=0 at once. After release, a fresh load returns correct data and no stale response appears.
